// File: rtl/alu_writeback_pipe.sv
// alu_writeback_pipe: execute/writeback ALU pipe with RAW stall; define ALU_PIPE_FORWARD_EN to forward instead of stalling
module alu_writeback_pipe #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_sr1,
    input  logic [AW-1:0] in_sr2,
    input  logic [AW-1:0] in_dr,
    output logic [AW-1:0] sr1,
    output logic [AW-1:0] sr2,
    input  logic [DW-1:0] rdData1,
    input  logic [DW-1:0] rdData2,
    output logic [DW-1:0] wrData,
    output logic [AW-1:0] dr,
    output logic          write,
    output logic          busy
);
    logic          e_valid_q, write_q;
    logic [2:0]    e_op_q;
    logic [AW-1:0] e_dr_q, dr_q;
    logic [DW-1:0] e_a_q, e_b_q, wr_data_q, result, op_a_d, op_b_d;
    logic          accept;
    assign sr1    = in_sr1;
    assign sr2    = in_sr2;
    assign wrData = wr_data_q;
    assign dr     = dr_q;
    assign write  = write_q;
    assign busy   = e_valid_q | write_q;
    assign accept = in_valid & in_ready;
`ifdef ALU_PIPE_FORWARD_EN
    assign in_ready = 1'b1;
    assign op_a_d = (e_valid_q && in_sr1 == e_dr_q) ? result :
                    (write_q && in_sr1 == dr_q) ? wr_data_q : rdData1;
    assign op_b_d = (e_valid_q && in_sr2 == e_dr_q) ? result :
                    (write_q && in_sr2 == dr_q) ? wr_data_q : rdData2;
`else
    logic hazard;
    // W is checked too: the bank has not yet committed the value being written this cycle
    assign hazard = in_valid & ((e_valid_q & (in_sr1 == e_dr_q | in_sr2 == e_dr_q)) |
                                (write_q & (in_sr1 == dr_q | in_sr2 == dr_q)));
    assign in_ready = reset | ~hazard;
    assign op_a_d = rdData1;
    assign op_b_d = rdData2;
`endif
    always_comb begin
        case (e_op_q)
            3'd0:    result = e_a_q + e_b_q;
            3'd1:    result = e_a_q - e_b_q;
            3'd2:    result = e_a_q & e_b_q;
            3'd3:    result = e_a_q | e_b_q;
            3'd4:    result = e_a_q ^ e_b_q;
            3'd5:    result = {{(DW-1){1'b0}}, $signed(e_a_q) < $signed(e_b_q)};
            3'd6:    result = e_a_q << e_b_q[4:0];
            default: result = e_a_q >> e_b_q[4:0];
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid_q <= 1'b0;
            e_op_q    <= '0;
            e_dr_q    <= '0;
            e_a_q     <= '0;
            e_b_q     <= '0;
            write_q   <= 1'b0;
            dr_q      <= '0;
            wr_data_q <= '0;
        end else begin
            e_valid_q <= accept;
            if (accept) begin
                e_op_q <= in_op;
                e_dr_q <= in_dr;
                e_a_q  <= op_a_d;
                e_b_q  <= op_b_d;
            end
            write_q   <= e_valid_q;
            dr_q      <= e_dr_q;
            wr_data_q <= result;
        end
    end
endmodule

// File: tb/tb_alu_writeback_pipe.sv
// tb_alu_writeback_pipe: directed and random checks of alu_writeback_pipe against an architectural register-file model
module tb_alu_writeback_pipe;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
    logic        in_ready, write, busy;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_sr1 = '0, in_sr2 = '0, in_dr = '0, sr1, sr2, dr;
    logic [31:0] rdData1, rdData2, wrData;
    logic [31:0] bank [32];
    logic [31:0] ref_rf [32];
    logic        pl_we = 1'b0;
    logic [4:0]  pl_a = '0;
    logic [31:0] pl_d = '0;
    int checks = 0, failures = 0;
    typedef struct packed { logic [4:0] d; logic [31:0] v; } wr_t;
    wr_t exp_q [$];
`ifdef ALU_PIPE_FORWARD_EN
    localparam int DEP_STALL = 0;
`else
    localparam int DEP_STALL = 2;
`endif

    alu_writeback_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .sr1(sr1), .sr2(sr2),
        .rdData1(rdData1), .rdData2(rdData2), .wrData(wrData), .dr(dr), .write(write), .busy(busy)
    );

    always #5 clk = ~clk;
    assign rdData1 = bank[sr1];
    assign rdData2 = bank[sr2];
    always @(posedge clk) begin
        if (pl_we) bank[pl_a] <= pl_d;
        else if (write) bank[dr] <= wrData;
    end

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // every time advance goes through here so each write pulse is matched against the model
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (write === 1'b1) begin
            chk("write_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_dr", {27'd0, dr}, {27'd0, e.d});
                chk("wr_data", wrData, e.v);
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, output int stalls);
        logic [31:0] v;
        in_valid = 1'b1; in_op = op; in_dr = d; in_sr1 = s1; in_sr2 = s2; stalls = 0;
        #1;
        while (!in_ready && stalls < 10) begin
            stalls++;
            tick();
            #1;
        end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        v = alu(op, ref_rf[s1], ref_rf[s2]);
        ref_rf[d] = v;
        exp_q.push_back(wr_t'{d: d, v: v});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (5) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int st, st2;
        logic [31:0] sweep_exp [8];
        sweep_exp = '{32'h00000003, 32'hFFFFFFFB, 32'h00000004, 32'hFFFFFFFF,
                      32'hFFFFFFFB, 32'h00000001, 32'hFFFFFFF0, 32'h0FFFFFFF};
        #1;
        chk("ready_in_reset", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 32; k++) begin
            pl_we = 1'b1; pl_a = 5'(k);
            pl_d = (k == 8) ? 32'hFFFFFFFF : (k == 9) ? 32'd4 : 32'(10 * k);
            ref_rf[k] = pl_d;
            tick();
        end
        pl_we = 1'b0;
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_dr", {27'd0, dr}, 32'd0);
        chk("rst_wrdata", wrData, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
        in_sr1 = 5'd13; in_sr2 = 5'd22; #1;
        chk("sr1_pass", {27'd0, sr1}, 32'd13);
        chk("sr2_pass", {27'd0, sr2}, 32'd22);
        // independent back-to-back
        issue(3'd0, 5'd3, 5'd1, 5'd2, st);
        chk("indep_stall1", 32'(st), 32'd0);
        issue(3'd1, 5'd4, 5'd5, 5'd2, st);
        chk("indep_stall2", 32'(st), 32'd0);
        chk("consec_write", {31'd0, write}, 32'd1);
        drain();
        chk("bank_r3", bank[3], 32'd30);
        chk("bank_r4", bank[4], 32'd30);
        // dependent chain
        issue(3'd0, 5'd6, 5'd1, 5'd2, st);
        issue(3'd0, 5'd7, 5'd6, 5'd1, st2);
        chk("dep_stall", 32'(st2), 32'(DEP_STALL));
        drain();
        chk("bank_r7", bank[7], 32'd40);
        // opcode sweep
        for (int op = 0; op < 8; op++) issue(3'(op), 5'(10 + op), 5'd8, 5'd9, st);
        drain();
        for (int op = 0; op < 8; op++) chk($sformatf("sweep_op%0d", op), bank[10 + op], sweep_exp[op]);
        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 300; n++) begin
            issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), st);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        for (int k = 0; k < 32; k++) chk($sformatf("bank_r%0d", k), bank[k], ref_rf[k]);
        // reset mid-flight: the accepted instruction must never reach the bank
        issue(3'd0, 5'd20, 5'd1, 5'd2, st);
        void'(exp_q.pop_back());
        ref_rf[20] = 32'd200;
        reset = 1'b1; in_valid = 1'b1; in_sr1 = 5'd20; in_sr2 = 5'd20;
        #1;
        chk("ready_during_reset", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("midrst_write", {31'd0, write}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_bank", bank[20], ref_rf[20]);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
